// File: rtl/control_unit.sv
// Microsequencer for the 16-bit processor: three-cycle fetch, opcode decode and a
// two-cycle memory tail for LOAD/STORE. All outputs are combinational decodes of state.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir_opcode,
    input  logic       z_flag,
    output logic [9:0] C_bus_ctrl_sig,
    output logic [3:0] select,
    output logic       PC_INC,
    output logic       AC_INC,
    output logic       RA_INC,
    output logic       RB_INC,
    output logic       RC_INC,
    output logic       read,
    output logic       write,
    output logic       LDIR,
    output logic [1:0] alu_op,
    output logic       halted
);

    localparam logic [2:0] StFetch1 = 3'd0;
    localparam logic [2:0] StFetch2 = 3'd1;
    localparam logic [2:0] StFetch3 = 3'd2;
    localparam logic [2:0] StDecode = 3'd3;
    localparam logic [2:0] StMem1   = 3'd4;
    localparam logic [2:0] StMem2   = 3'd5;
    localparam logic [2:0] StHalt   = 3'd6;

    localparam logic [3:0] ClsNop   = 4'h0;
    localparam logic [3:0] ClsMvr   = 4'h1;
    localparam logic [3:0] ClsMva   = 4'h2;
    localparam logic [3:0] ClsInc   = 4'h3;
    localparam logic [3:0] ClsLoad  = 4'h4;
    localparam logic [3:0] ClsStore = 4'h5;
    localparam logic [3:0] ClsAdd   = 4'h6;
    localparam logic [3:0] ClsSub   = 4'h7;
    localparam logic [3:0] ClsJmpz  = 4'h8;
    localparam logic [3:0] ClsJmp   = 4'h9;
    localparam logic [3:0] ClsHalt  = 4'hF;

    logic [2:0] state_q, state_d;
    logic [3:0] cls, idx;

    assign cls = ir_opcode[7:4];
    assign idx = ir_opcode[3:0];

    // Register index -> C-bus write-enable bit; idx 9-15 select no register.
    function automatic logic [9:0] wr_bit(input logic [3:0] i);
        logic [9:0] b;
        b = 10'h000;
        case (i)
            4'd0:    b[2] = 1'b1;
            4'd1:    b[5] = 1'b1;
            4'd2:    b[4] = 1'b1;
            4'd3:    b[3] = 1'b1;
            4'd4:    b[8] = 1'b1;
            4'd5:    b[7] = 1'b1;
            4'd6:    b[6] = 1'b1;
            4'd7:    b[0] = 1'b1;
            4'd8:    b[9] = 1'b1;
            default: b    = 10'h000;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        C_bus_ctrl_sig = 10'h000;
        select         = 4'd0;
        PC_INC         = 1'b0;
        AC_INC         = 1'b0;
        RA_INC         = 1'b0;
        RB_INC         = 1'b0;
        RC_INC         = 1'b0;
        read           = 1'b0;
        write          = 1'b0;
        LDIR           = 1'b0;
        alu_op         = 2'b00;
        halted         = 1'b0;

        // Outputs are forced quiet for the whole reset cycle, whatever state we are in.
        if (!reset) begin
            case (state_q)
                StFetch1: begin
                    select            = 4'd8;
                    C_bus_ctrl_sig[1] = 1'b1;
                    state_d           = StFetch2;
                end
                StFetch2: begin
                    read    = 1'b1;
                    PC_INC  = 1'b1;
                    state_d = StFetch3;
                end
                StFetch3: begin
                    LDIR    = 1'b1;
                    state_d = StDecode;
                end
                StDecode: begin
                    state_d = StFetch1;
                    case (cls)
                        ClsMvr: begin
                            select            = idx;
                            C_bus_ctrl_sig[0] = 1'b1;
                        end
                        ClsMva: begin
                            select         = 4'd7;
                            C_bus_ctrl_sig = wr_bit(idx);
                        end
                        ClsInc: begin
                            case (idx)
                                4'd4:    RA_INC = 1'b1;
                                4'd5:    RB_INC = 1'b1;
                                4'd6:    RC_INC = 1'b1;
                                4'd7:    AC_INC = 1'b1;
                                4'd8:    PC_INC = 1'b1;
                                default: ;
                            endcase
                        end
                        ClsLoad, ClsStore: begin
                            select            = idx;
                            C_bus_ctrl_sig[1] = 1'b1;
                            state_d           = StMem1;
                        end
                        ClsAdd, ClsSub: begin
                            select            = idx;
                            alu_op            = (cls == ClsAdd) ? 2'b01 : 2'b10;
                            C_bus_ctrl_sig[0] = 1'b1;
                        end
                        ClsJmpz: begin
                            if (z_flag) begin
                                select            = idx;
                                C_bus_ctrl_sig[9] = 1'b1;
                            end
                        end
                        ClsJmp: begin
                            select            = idx;
                            C_bus_ctrl_sig[9] = 1'b1;
                        end
                        ClsHalt: state_d = StHalt;
                        default: ;
                    endcase
                end
                StMem1: begin
                    if (cls == ClsLoad) begin
                        read = 1'b1;
                    end else begin
                        select            = 4'd7;
                        C_bus_ctrl_sig[2] = 1'b1;
                    end
                    state_d = StMem2;
                end
                StMem2: begin
                    if (cls == ClsLoad) begin
                        select            = 4'd0;
                        C_bus_ctrl_sig[0] = 1'b1;
                    end else begin
                        write = 1'b1;
                    end
                    state_d = StFetch1;
                end
                StHalt: begin
                    halted  = 1'b1;
                    state_d = StHalt;
                end
                default: state_d = StFetch1;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected output vectors are queued as each cycle
// is driven and compared against the DUT at the following falling edge.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir_opcode;
    logic       z_flag;
    logic [9:0] C_bus_ctrl_sig;
    logic [3:0] select;
    logic       PC_INC, AC_INC, RA_INC, RB_INC, RC_INC;
    logic       read, write, LDIR;
    logic [1:0] alu_op;
    logic       halted;

    control_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ir_opcode      (ir_opcode),
        .z_flag         (z_flag),
        .C_bus_ctrl_sig (C_bus_ctrl_sig),
        .select         (select),
        .PC_INC         (PC_INC),
        .AC_INC         (AC_INC),
        .RA_INC         (RA_INC),
        .RB_INC         (RB_INC),
        .RC_INC         (RC_INC),
        .read           (read),
        .write          (write),
        .LDIR           (LDIR),
        .alu_op         (alu_op),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [24:0] vec;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [4:0] IPC = 5'b10000;
    localparam logic [4:0] IAC = 5'b01000;
    localparam logic [4:0] IRA = 5'b00100;
    localparam logic [4:0] IRB = 5'b00010;
    localparam logic [4:0] IRC = 5'b00001;

    // {C_bus, select, PC/AC/RA/RB/RC_INC, read, write, LDIR, alu_op, halted}
    function automatic logic [24:0] mk(input logic [9:0] cb, input logic [3:0] sel,
                                       input logic [4:0] inc, input logic rd,
                                       input logic wr, input logic ld,
                                       input logic [1:0] alu, input logic h);
        return {cb, sel, inc, rd, wr, ld, alu, h};
    endfunction

    logic [24:0] obs;
    assign obs = {C_bus_ctrl_sig, select, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC,
                  read, write, LDIR, alu_op, halted};

    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.tag, obs, e.vec);
        end
    end

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [24:0] v);
        exp_t e;
        e.tag = tag;
        e.vec = v;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch();
        cyc("fetch1", mk(10'h002, 4'd8, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc("fetch2", mk(10'h000, 4'd0, IPC,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc("fetch3", mk(10'h000, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0));
    endtask

    // One single-cycle instruction: fetch plus the expected DECODE vector.
    task automatic single(input string tag, input logic [7:0] ir, input logic z,
                          input logic [24:0] dec);
        ir_opcode = ir;
        z_flag    = z;
        fetch();
        cyc(tag, dec);
    endtask

    localparam logic [24:0] Zero = 25'd0;

    initial begin
        reset     = 1'b1;
        ir_opcode = 8'h00;
        z_flag    = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset0", Zero);
        cyc("reset1", Zero);
        reset = 1'b0;

        single("nop_a", 8'h00, 1'b0, Zero);
        single("nop_b", 8'h00, 1'b0, Zero);
        single("mvr_ra", 8'h14, 1'b0, mk(10'h001, 4'd4, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("mvr_i12", 8'h1C, 1'b0, mk(10'h001, 4'd12, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("mva_rb", 8'h25, 1'b0, mk(10'h080, 4'd7, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("mva_i10", 8'h2A, 1'b0, mk(10'h000, 4'd7, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("inc_ra", 8'h34, 1'b0, mk(10'h000, 4'd0, IRA, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("inc_rb", 8'h35, 1'b0, mk(10'h000, 4'd0, IRB, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("inc_rc", 8'h36, 1'b0, mk(10'h000, 4'd0, IRC, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("inc_ac", 8'h37, 1'b0, mk(10'h000, 4'd0, IAC, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("inc_pc", 8'h38, 1'b0, mk(10'h000, 4'd0, IPC, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("inc_i11", 8'h3B, 1'b0, Zero);
        single("add_r2", 8'h62, 1'b0, mk(10'h001, 4'd2, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0));
        single("sub_r1", 8'h71, 1'b0, mk(10'h001, 4'd1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0));
        single("jmpz_z0", 8'h86, 1'b0, Zero);
        single("jmpz_z1", 8'h86, 1'b1, mk(10'h200, 4'd6, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("jmp_pc", 8'h98, 1'b0, mk(10'h200, 4'd8, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        single("illegal", 8'hA3, 1'b1, Zero);

        // LOAD via RB
        single("load_dec", 8'h45, 1'b0, mk(10'h002, 4'd5, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc("load_mem1", mk(10'h000, 4'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc("load_mem2", mk(10'h001, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));

        // STORE via R3
        single("store_dec", 8'h53, 1'b0, mk(10'h002, 4'd3, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc("store_mem1", mk(10'h004, 4'd7, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc("store_mem2", mk(10'h000, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0));

        // Reset during MEM1 of a LOAD aborts it
        single("abort_dec", 8'h45, 1'b0, mk(10'h002, 4'd5, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        reset = 1'b1;
        cyc("abort_mem1", Zero);
        cyc("abort_next", Zero);
        reset = 1'b0;
        single("after_abort", 8'h14, 1'b0,
               mk(10'h001, 4'd4, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));

        // HALT holds with no strobes, leaves only via reset
        single("halt_dec", 8'hF0, 1'b0, Zero);
        for (int i = 0; i < 20; i++) begin
            ir_opcode = 8'h14;
            z_flag    = i[0];
            cyc("halt_hold", mk(10'h000, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
        end
        reset = 1'b1;
        cyc("halt_reset", Zero);
        reset = 1'b0;
        single("post_halt", 8'h00, 1'b0, Zero);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) check("drain", 25'(q.size()), 25'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Microsequencer that drives the register file, bus, memory strobes and ALU of the 16-bit processor. It runs a fixed fetch sequence, decodes the 8-bit opcode held in IR, and issues C-bus write enables, the 4-bit source select, increment strobes, memory read/write and ALU operation for each instruction. It sits directly upstream of the register unit and consumes only IR opcode and the ALU zero flag.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ir_opcode  in  8  IR[15:8]; [7:4] class, [3:0] register index idx
- z_flag  in  1  ALU zero flag, sampled combinationally in DECODE
- C_bus_ctrl_sig  out  10  write enables: [9]PC [8]RA [7]RB [6]RC [5]R1 [4]R2 [3]R3 [2]DR [1]AR [0]AC
- select  out  4  bus source: 0 DR, 1 R1, 2 R2, 3 R3, 4 RA, 5 RB, 6 RC, 7 AC, 8 PC
- PC_INC, AC_INC, RA_INC, RB_INC, RC_INC  out  1 each  increment strobes
- read  out  1  DR <- RAM at this edge
- write  out  1  RAM[AR] <- DR at this edge
- LDIR  out  1  IR <- DR at this edge
- alu_op  out  2  00 pass B (bus), 01 AC+B, 10 AC-B, 11 reserved
- halted  out  1  high in HALT

## Operation
- States: FETCH1, FETCH2, FETCH3, DECODE, MEM1, MEM2, HALT. Outputs are combinational decodes of state (and ir_opcode/z_flag in DECODE/MEM states). All outputs not listed are 0. alu_op defaults to 00.
- FETCH1: select=8, C_bus[1]=1 (AR<-PC). -> FETCH2.
- FETCH2: read=1, PC_INC=1. -> FETCH3.
- FETCH3: LDIR=1. -> DECODE.
- DECODE, by class. Write-bit map for idx: 0->[2], 1->[5], 2->[4], 3->[3], 4->[8], 5->[7], 6->[6], 7->[0], 8->[9], 9-15 -> none.
  - 0x0 NOP: -> FETCH1.
  - 0x1 MVR: select=idx, C_bus[0]=1. -> FETCH1.
  - 0x2 MVA: select=7, write bit of idx. -> FETCH1.
  - 0x3 INC: idx 4/5/6/7/8 pulse RA/RB/RC/AC/PC_INC. Other idx values: no action. -> FETCH1.
  - 0x4 LOAD: select=idx, C_bus[1]=1. -> MEM1.
  - 0x5 STORE: select=idx, C_bus[1]=1. -> MEM1.
  - 0x6 ADD / 0x7 SUB: select=idx, alu_op=01/10, C_bus[0]=1. -> FETCH1.
  - 0x8 JMPZ: if z_flag, select=idx, C_bus[9]=1. -> FETCH1.
  - 0x9 JMP: select=idx, C_bus[9]=1. -> FETCH1.
  - 0xF HALT: -> HALT.
  - 0xA-0xE: illegal, treated as NOP.
- MEM1:
  - LOAD: read=1.
  - STORE: select=7, C_bus[2]=1 (DR<-AC).
  - -> MEM2.
- MEM2:
  - LOAD: select=0, C_bus[0]=1.
  - STORE: write=1.
  - -> FETCH1.
- HALT: all strobes 0, halted=1. Leaves only via reset.
- select for idx 9-15 is passed through unchanged. The bus reads 0 for these values, so no register is written with junk (write-bit map gives none).

## Timing
- While reset is high, all outputs are 0. State becomes FETCH1 at the first edge with reset high. Reset asserted in any state, including mid-LOAD/STORE or HALT, aborts the instruction with no further strobes.
- Cycle counts:
  - Single-cycle classes: 4 cycles (3 fetch + DECODE).
  - LOAD and STORE: 6 cycles.
  - HALT: enters HALT after 4 cycles.
- ir_opcode is valid from the edge that ends FETCH3 and must stay stable through MEM2. The block ignores ir_opcode in the FETCH states.
- The DECODE write-enable and the ALU result use the same edge. The register unit captures at the edge that ends DECODE.
- At most one C_bus_ctrl_sig bit is high in any cycle. read and write are never high together.

## Test plan
- Reset then release, IR=0x00: FETCH1 shows select=8/C_bus=0x002, FETCH2 read=1/PC_INC=1, FETCH3 LDIR=1, DECODE all zero; the pattern repeats every 4 cycles.
- IR=0x14 (MVR RA): DECODE select=4, C_bus=0x001; next cycle back in FETCH1.
- IR=0x45 (LOAD via RB): DECODE select=5/C_bus=0x002, MEM1 read=1, MEM2 select=0/C_bus=0x001; FETCH1 on cycle 7.
- IR=0x53 (STORE via R3): DECODE C_bus=0x002 select=3, MEM1 select=7/C_bus=0x004, MEM2 write=1.
- IR=0x86 with z_flag=0 gives C_bus=0 in DECODE. With z_flag=1 it gives select=6/C_bus=0x200. IR=0x3B (INC idx 11) gives no strobes.
- IR=0xF0: halted=1 held 20 cycles with zero strobes. Assert reset during MEM1 of a LOAD: the next cycle has all outputs 0, then FETCH1 after release.
